// File: rtl/watch_pkg.sv
// Shared types, segment constants and BCD time helpers for the stopwatch and countdown timer.
package watch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_units;
        bcd_t sec_tens;
        bcd_t sec_units;
    } mmss_t;

    // Active-low segments, bits [6:0] = g..a, bit 7 = dp (1 = dark).
    localparam int         SEG_DP_BIT = 7;
    localparam logic [7:0] SEG_0      = 8'hC0;
    localparam logic [7:0] SEG_1      = 8'hF9;
    localparam logic [7:0] SEG_2      = 8'hA4;
    localparam logic [7:0] SEG_3      = 8'hB0;
    localparam logic [7:0] SEG_4      = 8'h99;
    localparam logic [7:0] SEG_5      = 8'h92;
    localparam logic [7:0] SEG_6      = 8'h82;
    localparam logic [7:0] SEG_7      = 8'hF8;
    localparam logic [7:0] SEG_8      = 8'h80;
    localparam logic [7:0] SEG_9      = 8'h90;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    function automatic bcd_t clamp_digit(bcd_t d, bcd_t max_val);
        return (d > max_val) ? max_val : d;
    endfunction

    function automatic mmss_t clamp_preset(bcd_t mt, bcd_t mu, bcd_t st, bcd_t su);
        mmss_t r;
        r.min_tens  = clamp_digit(mt, 4'd9);
        r.min_units = clamp_digit(mu, 4'd9);
        r.sec_tens  = clamp_digit(st, 4'd5);
        r.sec_units = clamp_digit(su, 4'd9);
        return r;
    endfunction

    function automatic logic is_zero(mmss_t t);
        return t == '0;
    endfunction

    // One-second borrow chain; saturates at 00:00.
    function automatic mmss_t decrement(mmss_t t);
        mmss_t r;
        r = t;
        if (!is_zero(t)) begin
            if (t.sec_units != 4'd0) begin
                r.sec_units = t.sec_units - 4'd1;
            end else begin
                r.sec_units = 4'd9;
                if (t.sec_tens != 4'd0) begin
                    r.sec_tens = t.sec_tens - 4'd1;
                end else begin
                    r.sec_tens = 4'd5;
                    if (t.min_units != 4'd0) begin
                        r.min_units = t.min_units - 4'd1;
                    end else begin
                        r.min_units = 4'd9;
                        r.min_tens  = t.min_tens - 4'd1;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder with a decimal-point input.
module bcd_to_seg
    import watch_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        seg[SEG_DP_BIT] = ~dp;
    end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer: BCD preset, one-second decrement while running, done at 00:00.
module countdown_timer
    import watch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] set_min_tens,
    input  logic [3:0] set_min_units,
    input  logic [3:0] set_sec_tens,
    input  logic [3:0] set_sec_units,
    output logic [7:0] seg_minutes_tens,
    output logic [7:0] seg_minutes_units,
    output logic [7:0] seg_seconds_tens,
    output logic [7:0] seg_seconds_units,
    output logic       running,
    output logic       done
);

    localparam int             DIV_W   = $clog2(TICKS_PER_SEC);
    localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(TICKS_PER_SEC - 1);

    state_t           state, next_state;
    mmss_t            count, next_count;
    logic [DIV_W-1:0] div, next_div;
    logic [7:0]       enc_min_tens, enc_min_units, enc_sec_tens, enc_sec_units;

    always_comb begin
        next_state = state;
        next_count = count;
        next_div   = div;
        if (load) begin
            next_state = IDLE;
            next_count = clamp_preset(set_min_tens, set_min_units, set_sec_tens, set_sec_units);
            next_div   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !is_zero(count)) begin
                        next_state = RUN;
                        next_div   = '0;
                    end
                end
                RUN: begin
                    // The divider still advances on the pause edge so the partial second is preserved.
                    if (div == DIV_TOP) begin
                        next_div   = '0;
                        next_count = decrement(count);
                    end else begin
                        next_div = div + 1'b1;
                    end
                    if (div == DIV_TOP && is_zero(next_count)) begin
                        next_state = EXPIRED;
                    end else if (pause) begin
                        next_state = PAUSED;
                    end
                end
                PAUSED: begin
                    if (start && !pause && !is_zero(count)) begin
                        next_state = RUN;
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    bcd_to_seg u_seg_min_tens  (.digit(count.min_tens),  .dp(1'b0), .seg(enc_min_tens));
    bcd_to_seg u_seg_min_units (.digit(count.min_units), .dp(1'b1), .seg(enc_min_units));
    bcd_to_seg u_seg_sec_tens  (.digit(count.sec_tens),  .dp(1'b0), .seg(enc_sec_tens));
    bcd_to_seg u_seg_sec_units (.digit(count.sec_units), .dp(1'b0), .seg(enc_sec_units));

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values, avoiding order races.
        if (!rst) begin
            state             <= IDLE;
            count             <= '0;
            div               <= '0;
            running           <= 1'b0;
            done              <= 1'b0;
            seg_minutes_tens  <= SEG_0;
            seg_minutes_units <= SEG_0 & ~(8'h1 << SEG_DP_BIT);
            seg_seconds_tens  <= SEG_0;
            seg_seconds_units <= SEG_0;
        end else begin
            state             <= next_state;
            count             <= next_count;
            div               <= next_div;
            running           <= (next_state == RUN);
            done              <= (next_state == EXPIRED);
            seg_minutes_tens  <= enc_min_tens;
            seg_minutes_units <= enc_min_units;
            seg_seconds_tens  <= enc_sec_tens;
            seg_seconds_units <= enc_sec_units;
        end
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

MM:SS countdown timer, the down-counting counterpart of the stopwatch. It loads a BCD preset, decrements it once per second while running, and raises `done` when it reaches 00:00. It drives four 7-segment digit buses with the same encoding and display layout as the stopwatch, so both blocks can share the board display and mux.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 100_000_000: `clk` cycles per one-second tick. Must be at least 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  **synchronous, active-low** reset. It is sampled on the `clk` rising edge.
- `load`  in  1  level; copies the preset into the counter.
- `start`  in  1  level; begins or resumes counting.
- `pause`  in  1  level; suspends counting.
- `set_min_tens`, `set_min_units`, `set_sec_tens`, `set_sec_units`  in  4 each  BCD preset digits.
- `seg_minutes_tens`, `seg_minutes_units`, `seg_seconds_tens`, `seg_seconds_units`  out  8 each  7-segment digit buses.
- `running`  out  1  high in state RUN.
- `done`  out  1  high in state EXPIRED.

## Operation
- Segment encoding:
  - Active-low.
  - Bits [6:0] = g,f,e,d,c,b,a; bit [7] = dp.
  - dp is lit (0) only on `seg_minutes_units`, acting as the colon. It is 1 on all other buses.
- States: IDLE, RUN, PAUSED, EXPIRED. Priority, highest first:
  - `rst`=0: IDLE, all digits 0, divider 0.
  - `load`=1, any state: IDLE, digits ← clamped preset, divider 0.
  - `pause`=1 in RUN: PAUSED. `pause` beats `start` when both are asserted.
  - `start`=1 in IDLE or PAUSED with count ≠ 00:00: RUN. The divider is cleared when coming from IDLE and kept when coming from PAUSED.
  - `start` with count = 00:00: no effect.
  - `start` or `pause` in EXPIRED: no effect. Only `load` or reset leaves EXPIRED.
- Clamping on load, applied per digit:
  - Any digit > 9 loads as 9.
  - `set_sec_tens` > 5 loads as 5.
  - Maximum preset is 99:59.
- Divider:
  - Counts 0..TICKS_PER_SEC-1, and only in RUN.
  - At the edge where it equals TICKS_PER_SEC-1, it wraps to 0 and the count decrements by one second.
- Decrement rules:
  - `sec_units` 0→9 with a borrow; otherwise −1.
  - A borrow takes `sec_tens` 0→5 with a borrow; otherwise −1.
  - A borrow takes `min_units` 0→9 with a borrow; otherwise −1.
  - A borrow decrements `min_tens`.
  - No wrap below 00:00.
- When a decrement produces 00:00, the same edge moves the state to EXPIRED.

## Timing
- Reset values:
  - State IDLE; `running`=0, `done`=0.
  - `seg_minutes_units` = 8'h40 ('0' with dp lit).
  - The other three seg outputs = 8'hC0 ('0').
- `start` sampled at edge E (from IDLE): `running`=1 after E. First decrement at edge E+TICKS_PER_SEC, then every TICKS_PER_SEC edges.
- Resuming from PAUSED: the remaining partial second is kept. With divider value d at pause, the next decrement comes TICKS_PER_SEC−d edges after the `start` edge.
- `done` and `running` are registered from the state and change on the same edge as the state.
- Seg outputs are registered from the digit registers and lag a digit change by exactly 1 cycle.
- `load` while RUN takes effect on that edge. Any tick due on that edge is discarded.
- Reset mid-RUN overrides everything on that edge.

## Structure
- Shared package `watch_pkg`:
  - State enum (IDLE, RUN, PAUSED, EXPIRED).
  - 4-bit BCD digit type.
  - Segment constants for 0–9, the dp bit position, and SEG_BLANK.
  - The stopwatch reuses the same package.
- Sub-module `bcd_to_seg`: combinational BCD→7-seg with a dp input, instantiated four times. Its outputs are registered in `countdown_timer`.
- The divider, borrow chain and FSM live inline in `countdown_timer`.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset for 2 cycles → seg = 40,C0,C0,C0 (min_units bus 40, the other three C0); `running`=0, `done`=0.
- Load 00:03, `start` at edge E → count 00:02/00:01/00:00 at E+4/E+8/E+12. `done`=1 and `running`=0 at E+12; segs show 00:00 at E+13.
- Load 10:00, run one tick → 09:59. Load 01:00, run one tick → 00:59.
- Load 00:05, start, `pause` held 1 cycle at E+2, `start` 10 cycles later at edge R → decrement to 00:04 at edge R+2. Count stays frozen while paused.
- Load digits 7,C,9,F (mm:ss = 7C:9F) → loads 79:59. Load 00:00 then `start` → stays IDLE, `running`=0.
- `start` and `pause` asserted together in PAUSED → stays PAUSED. `rst`=0 mid-RUN → IDLE with outputs at reset values on the next edge.
